cache_pmu_multi: RTL

Multi-channel, parametrised performance monitoring unit for the cache subsystem. Each channel watches one cache's request/stall handshake (I-cache, D-cache, future L2 ports) and counts accesses, misses, stalled cycles and longest single stall. Counters have a global enable, a synchronous clear, selectable saturate/wrap behaviour with sticky overflow flags, and a registered read-out port for a debug/CSR block.

---
 rtl/cache_pmu_multi_if.sv | 27 ++
 rtl/cache_pmu_multi.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cache_pmu_multi_if.sv
// Bus bundle for cache_pmu_multi: per-channel cache handshakes, control and CSR read-out.
interface cache_pmu_multi_if #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNT_W = 32
);
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]   cache_ren;
  logic [NCH-1:0]   cache_wen;
  logic [NCH-1:0]   cache_stall;
  logic             en;
  logic             clr;
  logic [CH_W-1:0]  rd_ch;
  logic [2:0]       rd_sel;
  logic [CNT_W-1:0] rd_data;
  logic [NCH-1:0]   ovf;

  modport master (
    output cache_ren, cache_wen, cache_stall, en, clr, rd_ch, rd_sel,
    input  rd_data, ovf
  );

  modport slave (
    input  cache_ren, cache_wen, cache_stall, en, clr, rd_ch, rd_sel,
    output rd_data, ovf
  );
endinterface

// File: rtl/cache_pmu_multi.sv
// Multi-channel cache PMU: per-channel access/miss/stall counters, longest stall and
// sticky overflow, with a registered counter read-out port.
module cache_pmu_multi #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input logic           clk_i,
  input logic           rst_ni,
  cache_pmu_multi_if.slave bus
);
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned NCNT = 7;
  localparam logic [CNT_W-1:0] AllOnes = '1;

  typedef enum logic {StIdle, StStall} state_e;

  state_e           state_q [NCH];
  state_e           state_d [NCH];
  logic [NCH-1:0]   cause_q, cause_d;
  logic [CNT_W-1:0] run_q [NCH];
  logic [CNT_W-1:0] run_d [NCH];
  logic [CNT_W-1:0] cnt_q [NCH][NCNT];
  logic [CNT_W-1:0] cnt_d [NCH][NCNT];
  logic [NCH-1:0]   ovf_q, ovf_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  // Per-channel increment requests: rd_cnt, wr_cnt, rd_miss, wr_miss, rd_stall, wr_stall.
  logic [5:0]       inc [NCH];

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    for (int c = 0; c < NCH; c++) begin
      inc[c] = '0;
      case (state_q[c])
        StIdle: begin
          inc[c][0] = bus.cache_ren[c];
          inc[c][1] = bus.cache_wen[c];
          if ((bus.cache_ren[c] | bus.cache_wen[c]) & bus.cache_stall[c]) begin
            cause_d[c] = ~bus.cache_ren[c];
            if (bus.cache_ren[c]) begin
              inc[c][2] = 1'b1;
              inc[c][4] = 1'b1;
            end else begin
              inc[c][3] = 1'b1;
              inc[c][5] = 1'b1;
            end
            run_d[c]   = CNT_W'(1);
            state_d[c] = StStall;
          end
        end
        StStall: begin
          if (bus.cache_stall[c]) begin
            if (cause_q[c]) inc[c][5] = 1'b1;
            else            inc[c][4] = 1'b1;
            run_d[c] = (run_q[c] == AllOnes) ? run_q[c] : run_q[c] + CNT_W'(1);
          end else begin
            run_d[c]   = '0;
            state_d[c] = StIdle;
          end
        end
        default: state_d[c] = StIdle;
      endcase

      if (bus.en) begin
        for (int k = 0; k < 6; k++) begin
          if (inc[c][k]) begin
            if (cnt_q[c][k] == AllOnes) begin
              ovf_d[c]    = 1'b1;
              cnt_d[c][k] = SATURATE ? AllOnes : '0;
            end else begin
              cnt_d[c][k] = cnt_q[c][k] + CNT_W'(1);
            end
          end
        end
        // run is clamped, so max_stall can never pass all-ones in either mode.
        if (run_d[c] > cnt_q[c][6]) cnt_d[c][6] = run_d[c];
      end

      if (bus.clr) begin
        for (int k = 0; k < NCNT; k++) cnt_d[c][k] = '0;
        ovf_d[c] = 1'b0;
      end
    end
  end

  // Unmatched channel or rd_sel == 7 falls through to zero.
  always_comb begin
    rd_data_d = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < NCNT; k++) begin
        if (bus.rd_ch == CH_W'(c) && bus.rd_sel == 3'(k)) rd_data_d = cnt_q[c][k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= StIdle;
        run_q[c]   <= '0;
        for (int k = 0; k < NCNT; k++) cnt_q[c][k] <= '0;
      end
      cause_q   <= '0;
      ovf_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.ovf     = ovf_q;
endmodule
